mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes driven by the CU's DMR/DMW).
- Sequences each access through a fixed-latency memory protocol and returns a one-cycle ack pulse.
- Produces stall signals that freeze the requesting pipeline stage until its access completes.
- Sits between the IF/MEM pipeline stages and the memory model.

Parameters:
- ADDR_W, 20, memory word-address width.
- DATA_W, 16, memory data width.
- LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- MAX_DM_STREAK, 3, number of consecutive contested data grants before fetch is forced a grant. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch read request; level, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  combinational: if_req & ~if_ack
- dm_re  in  1  data read request (DMR); level, held until dm_ack
- dm_we  in  1  data write request (DMW); level, held until dm_ack
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  data read result; valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse for data
- dm_stall  out  1  combinational: (dm_re|dm_we) & ~dm_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, streak 0, owner 0.
- Reset mid-access: the access is abandoned, no ack is issued, and mem_en/mem_we drop the next cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered except the two stall signals.
- IDLE: sample requests. If any request is present, latch the owner, address, write data and write flag, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration in IDLE: data request (dm_re|dm_we) beats if_req. If dm_re and dm_we are both high, the access is a write and the read is ignored.
- ISSUE: exactly 1 cycle. mem_en=1, mem_we=latched write flag, mem_addr/mem_wdata=latched values. Load the counter with LATENCY, then go to WAIT.
- WAIT: lasts exactly LATENCY cycles, with mem_en=0 throughout. On the last WAIT cycle, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE: exactly 1 cycle. Owner's ack=1 and owner's rdata is valid. The non-owner's rdata holds its previous value. A write ack leaves dm_rdata unchanged. Next state is always IDLE.
- No grant is made in the DONE cycle. The requester updates its request at the edge ending DONE, so a req still high in the following IDLE cycle is a new request.
- Latency: request first seen in IDLE cycle T -> mem_en in T+1 -> ack in T+2+LATENCY. Minimum request-to-request period is LATENCY+3 cycles.
- Request inputs are sampled only in IDLE. Dropping a request mid-access does not cancel the access; the ack is still issued.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 4-bit streak counter increments on each data grant made while if_req=1.
  - When streak==MAX_DM_STREAK and both sides request, fetch wins and streak clears.
  - Any fetch grant clears streak. Reset clears streak.
- Undefined: strict data priority; fetch may starve indefinitely. The streak logic is absent.

Test Plan:
1. Fetch read alone: LATENCY=2; if_req=1, if_addr=0x00010 in IDLE cycle T; memory returns 0xA5A5 in T+3 -> mem_en=1, mem_we=0, mem_addr=0x00010 in T+1 only; if_ack=1 and if_rdata=0xA5A5 in T+4 only; if_stall=1 during T..T+3.
2. Data write: dm_we=1, dm_addr=0x00200, dm_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 in T+1; dm_ack in T+4; dm_rdata unchanged.
3. Simultaneous requests: if_req and dm_re both asserted in cycle T -> data granted first, with dm_ack at T+4. Fetch granted at T+5, with mem_en at T+6 and if_ack at T+9.
4. Fairness: with MEM_ARB_FAIRNESS_EN defined, hold if_req and dm_re continuously -> grant order D,D,D,F,D,D,D,F. With the macro undefined -> D only, and if_ack never asserts.
5. Reset mid-access: assert rst in the first WAIT cycle of a data read -> no dm_ack is issued; all outputs are 0 in the cycle after the reset edge; a fresh if_req completes normally afterwards.
6. Both data strobes: dm_re=dm_we=1 -> single access with mem_we=1; exactly one dm_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with fixed-latency sequencing.
// Optional fetch anti-starvation streak logic is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int LATENCY       = 2,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       owner;   // 1 = data side owns the current access
  logic       wr;
  logic       dm_any;
  logic       grant_if;

  assign dm_any   = dm_re | dm_we;
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_any & ~dm_ack;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] streak;

  // Fetch is forced through after MAX_DM_STREAK contested data grants.
  assign grant_if = if_req & (~dm_any | (streak == 4'(MAX_DM_STREAK)));

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (state == IDLE && (dm_any || if_req)) begin
      if (grant_if)
        streak <= '0;
      else if (if_req)
        streak <= streak + 4'd1;
    end
  end
`else
  logic unused_streak_cfg;

  assign grant_if          = if_req & ~dm_any;
  assign unused_streak_cfg = |4'(MAX_DM_STREAK);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      wr        <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_any || if_req) begin
            owner     <= ~grant_if;
            wr        <= ~grant_if & dm_we;
            mem_en    <= 1'b1;
            mem_we    <= ~grant_if & dm_we;
            mem_addr  <= grant_if ? if_addr : dm_addr;
            mem_wdata <= grant_if ? '0 : dm_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= 4'(LATENCY);
          state  <= WAIT;
        end
        WAIT: begin
          // mem_rdata is valid only in the last WAIT cycle.
          if (cnt == 4'd1) begin
            state <= DONE;
            if (owner) begin
              dm_ack <= 1'b1;
              if (!wr)
                dm_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus hand-written
// sequences for contention, fairness and mid-access reset.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              dm_re;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .MAX_DM_STREAK(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data is driven only in the cycle LATENCY after the mem_en cycle.
  logic [15:0]  marr [0:255];
  logic [255:0] written = '0;
  logic [7:0]   rd_addr = '0;
  int           rd_cnt  = 0;

  function automatic logic [15:0] preset(input logic [7:0] a);
    return (a == 8'h10) ? 16'hA5A5 : {8'h10, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      marr[mem_addr[7:0]]    <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      rd_cnt  <= 1;
      rd_addr <= mem_addr[7:0];
    end else if (rd_cnt != 0 && rd_cnt < LATENCY) begin
      rd_cnt <= rd_cnt + 1;
    end else begin
      rd_cnt <= 0;
    end
  end

  assign mem_rdata = (rd_cnt == LATENCY) ?
                     (written[rd_addr] ? marr[rd_addr] : preset(rd_addr)) : 16'hDEAD;

  typedef struct {
    logic        ifq;
    logic        re;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        exp_we;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_if = '0;
  logic [15:0] exp_dm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_if = '0;
    exp_dm = '0;
  endtask

  // Entered just after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_vec(input vec_t v);
    if_req = v.ifq; dm_re = v.re; dm_we = v.we;
    if_addr = v.addr; dm_addr = v.addr; dm_wdata = v.wdata;
    #1;
    chk("stall_req", v.ifq ? if_stall : dm_stall, 1);
    for (int k = 1; k <= LATENCY + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("mem_en_issue", mem_en, 1);
        chk("mem_we_issue", mem_we, v.exp_we);
        chk("mem_addr_issue", mem_addr, v.addr);
        if (v.exp_we) chk("mem_wdata_issue", mem_wdata, v.wdata);
      end else begin
        chk("mem_en_idle", mem_en, 0);
      end
      chk("acks", {if_ack, dm_ack}, (k == LATENCY + 2) ? (v.ifq ? 2'b10 : 2'b01) : 2'b00);
      if (k == LATENCY + 2) begin
        if (v.ifq) exp_if = v.exp_rdata; else exp_dm = v.exp_rdata;
        chk("if_rdata", if_rdata, exp_if);
        chk("dm_rdata", dm_rdata, exp_dm);
        chk("stall_done", v.ifq ? if_stall : dm_stall, 0);
        if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
      end else begin
        chk("stall_busy", v.ifq ? if_stall : dm_stall, 1);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          dack_at, iack_at, men1, men2, nacks, late_acks;
    logic [7:0]  order;
    logic [15:0] d_seen, i_seen;
    vec_t        fv;

    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 16'hA5A5};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 20'h00200, 16'h1234, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 20'h00200, 16'h0000, 1'b0, 16'h1234};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 20'h00033, 16'hBEEF, 1'b1, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 20'h00033, 16'h0000, 1'b0, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 20'h00044, 16'h5A5A, 1'b1, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 20'h00044, 16'h0000, 1'b0, 16'h5A5A};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 20'h00005, 16'h0000, 1'b0, 16'h1005};

    do_reset();
    chk("reset_outputs", {mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall}, 0);
    chk("reset_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: data wins, fetch follows in the next IDLE.
    do_reset();
    if_req = 1'b1; dm_re = 1'b1; if_addr = 20'h00010; dm_addr = 20'h00005;
    dack_at = -1; iack_at = -1; men1 = -1; men2 = -1; d_seen = '0; i_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        if (men1 < 0) men1 = k; else if (men2 < 0) men2 = k;
      end
      if (dm_ack && dack_at < 0) begin dack_at = k; d_seen = dm_rdata; dm_re = 1'b0; end
      if (if_ack && iack_at < 0) begin iack_at = k; i_seen = if_rdata; if_req = 1'b0; end
    end
    chk("contend_dm_ack_cycle", dack_at, 4);
    chk("contend_mem_en_first", men1, 1);
    chk("contend_mem_en_second", men2, 6);
    chk("contend_if_ack_cycle", iack_at, 9);
    chk("contend_dm_rdata", d_seen, 16'h1005);
    chk("contend_if_rdata", i_seen, 16'hA5A5);

    // Both sides held continuously: record owner of each completed access.
    do_reset();
    if_req = 1'b1; dm_re = 1'b1;
    order = '0; nacks = 0;
    for (int k = 1; k <= 42; k++) begin
      @(posedge clk); #1;
      if (if_ack || dm_ack) begin
        order = {order[6:0], if_ack};
        nacks++;
      end
    end
    if_req = 1'b0; dm_re = 1'b0;
    chk("held_ack_count", nacks, 8);
`ifdef MEM_ARB_FAIRNESS_EN
    chk("grant_order", order, 8'h11);
`else
    chk("grant_order", order, 8'h00);
`endif

    // Reset in the first WAIT cycle of a data read abandons it.
    do_reset();
    run_vec(vecs[2]);
    dm_re = 1'b1; dm_addr = 20'h00005;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; dm_re = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ctrl", {mem_en, mem_we, if_ack, dm_ack}, 0);
    chk("midreset_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);
    rst = 1'b0;
    exp_if = '0; exp_dm = '0;
    late_acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (dm_ack || if_ack || mem_en) late_acks++;
    end
    chk("midreset_no_ack", late_acks, 0);
    fv = '{1'b1, 1'b0, 1'b0, 20'h00033, 16'h0000, 1'b0, 16'hBEEF};
    run_vec(fv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
